spu_ln_ctrl: RTL

// - Sequencer for the SPU layernorm datapath. Drives its state, counter and accumulate-enable inputs, and consumes its two finish flags.
// - Runs two passes over a row in the SPU buffer:
//   - pass 1 reads the row for the statistics (sum and sum of squares);
//   - pass 2 re-reads the row and writes the normalized int8 words back.
// - Sits between the SPU top-level command decoder and the datapath/buffer pair.

---
 rtl/spu_ln_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/spu_ln_ctrl.sv
// Layernorm sequencer: a statistics pass (SUM_COUNT), then SUM_DIV and SQRT handshakes,
// then an output pass (OUT) that re-reads the row and writes the normalized words back.
module spu_ln_ctrl #(
    parameter int ADDR_W       = 9,
    parameter int RD_LAT       = 1,
    parameter int SQRT_TIMEOUT = 200
) (
    input  logic              core_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   cfg_len,
    input  logic [ADDR_W-1:0] cfg_rd_base,
    input  logic [ADDR_W-1:0] cfg_wr_base,
    input  logic              sum_div_finish,
    input  logic              sqrt_reci_finish,
    output logic [2:0]        ln_state,
    output logic              sum_div_cnt,
    output logic [7:0]        sqrt_cnt,
    output logic              sum_en,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] buf_rd_addr,
    output logic              buf_wr_en,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int CW = ADDR_W + 2;

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_SUM  = 3'b001,
        S_DIV  = 3'b011,
        S_SQRT = 3'b100,
        S_OUT  = 3'b110
    } ln_state_t;

    ln_state_t         state, state_nxt;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W-1:0] rd_base_q, wr_base_q;
    logic [CW-1:0]     cyc, len_ext;
    logic [RD_LAT:0]   vld_pipe;
    logic              rd_en, sum_last, out_last, timeout, done_nxt, launch;

    assign len_ext  = CW'(len_q);
    assign rd_en    = ((state == S_SUM) || (state == S_OUT)) && (cyc < len_ext);
    // Both passes run past the last read until the delayed enable has drained
    assign sum_last = (cyc == len_ext + CW'(RD_LAT));
    assign out_last = (cyc == len_ext + CW'(RD_LAT - 1));
    assign timeout  = (sqrt_cnt == 8'(SQRT_TIMEOUT));
    assign launch   = (state == S_IDLE) && start && !abort && (cfg_len != '0);

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        err       = 1'b0;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_len == '0) done_nxt  = 1'b1;
                        else               state_nxt = S_SUM;
                    end
                end
                S_SUM:  if (sum_last) state_nxt = S_DIV;
                S_DIV:  if (sum_div_cnt && sum_div_finish) state_nxt = S_SQRT;
                S_SQRT: begin
                    if (sqrt_reci_finish) begin
                        state_nxt = S_OUT;
                    end else if (timeout) begin
                        state_nxt = S_IDLE;
                        err       = 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_last) begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            len_q       <= '0;
            rd_base_q   <= '0;
            wr_base_q   <= '0;
            cyc         <= '0;
            vld_pipe    <= '0;
            sum_div_cnt <= 1'b0;
            sqrt_cnt    <= '0;
            done        <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            if (launch) begin
                len_q     <= cfg_len;
                rd_base_q <= cfg_rd_base;
                wr_base_q <= cfg_wr_base;
            end
            // Returning to IDLE flushes any reads still in flight
            vld_pipe <= (state_nxt == S_IDLE) ? '0 : {vld_pipe[RD_LAT-1:0], rd_en};
            if (state_nxt != state) cyc <= '0;
            else if (rd_en || (state == S_SUM) || (state == S_OUT)) cyc <= cyc + 1'b1;
            sum_div_cnt <= (state == S_DIV) && (state_nxt == S_DIV);
            if ((state == S_SQRT) && (state_nxt == S_SQRT))
                sqrt_cnt <= (sqrt_cnt == 8'hFF) ? sqrt_cnt : sqrt_cnt + 8'd1;
            else
                sqrt_cnt <= '0;
        end
    end

    assign ln_state    = state;
    assign busy        = (state != S_IDLE);
    assign buf_rd_en   = rd_en;
    assign buf_rd_addr = rd_en ? rd_base_q + ADDR_W'(cyc) : '0;
    assign sum_en      = (state == S_SUM) && vld_pipe[RD_LAT];
    assign buf_wr_en   = (state == S_OUT) && vld_pipe[RD_LAT-1];
    assign buf_wr_addr = buf_wr_en ? wr_base_q + ADDR_W'(cyc - CW'(RD_LAT)) : '0;
endmodule
